seq_mul_unit: RTL and testbench
===============================

Name: seq_mul_unit

Overview:
Parametrised, handshaked successor to the fixed 16-bit multiply path and its (X+Y)*(X-Y) wrapper. It is an iterative shift-and-add multiplier with WIDTH-bit operands and a 2*WIDTH-bit product. A mode input selects plain product a*b or difference-of-squares (a+b)*(a-b). It replaces the delay-timed, RAM-staged multiply with a deterministic start/busy/done handshake for use by the datapath sequencer.

Parameters:
WIDTH, 16, operand width in bits (>=2); product is 2*WIDTH bits; run length is WIDTH cycles

Ports:
clk  input  1  system clock, all state updates on rising edge
re  input  1  reset; synchronous, active-high
start  input  1  request; sampled only when state is IDLE or DONE
mode  input  1  0: a*b; 1: (a+b)*(a-b)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse, high while state is DONE
prod  output  2*WIDTH  result; held until the next accepted start completes
ovf  output  1  high when prod[2*WIDTH-1:WIDTH] is nonzero; valid with prod

Behaviour:
- Reset: re high at an edge forces state IDLE, busy=0, done=0, prod=0, ovf=0, internal regs=0. Reset wins over start in the same cycle. Reset during RUN aborts the operation, and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge gives accept -> RUN. Otherwise remain in IDLE.
- RUN: the iteration counter runs 0..WIDTH-1, one multiplier bit per edge. After the WIDTH-th RUN edge the state goes to DONE. start is ignored in RUN.
- DONE: lasts one cycle. start=1 gives accept -> RUN (back-to-back). Otherwise the state goes to IDLE.
- Latency: start accepted at edge 0 -> done high in the cycle following edge WIDTH. Continuous start gives one result every WIDTH+1 cycles.
- Accept actions:
  - mode 0: multiplicand M=a, multiplier Q=b.
  - mode 1: M=(a+b) mod 2^WIDTH, Q=(a-b) mod 2^WIDTH. Both are unsigned; carry and borrow are discarded, matching the existing 16-bit wrap semantics.
  - Accumulator P is cleared. mode, a and b may change freely after accept.
- RUN step:
  - If Q[0]=1, then P[2W-1:W] += M, with carry kept in a (WIDTH+1)-bit intermediate.
  - Then {carry,P} shifts right by 1, and Q shifts right by 1.
  - The final P is the exact unsigned 2*WIDTH-bit product of M and Q. No truncation is allowed.
- prod and ovf update on the edge entering DONE. They keep their old value throughout RUN, and never show partial sums.
- busy=1 exactly in RUN. done=1 exactly in DONE. busy and done are never both high.
- Zero operands still take the full WIDTH cycles. There is no early termination, so latency is fixed.

Decomposition:
- Shared package seq_mul_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE.
  - mode constants MODE_MUL=0, MODE_DSQ=1.
  - a counter-width function clog2(WIDTH).
- One sub-module, seq_mul_prep: combinational operand preparation. It produces M and Q from a, b and mode (the adder and subtractor, WIDTH-parametrised).
- The FSM, counter and shift-add datapath stay in seq_mul_unit.

Test Plan:
- Reset: hold re 2 cycles with start=1 -> busy=0, done=0, prod=0, ovf=0, and no RUN entry.
- mode0, a=3, b=5, one-cycle start -> busy for 16 cycles, done pulse at cycle 17, prod=0x0000000F, ovf=0.
- mode0, a=0xFFFF, b=0xFFFF -> prod=0xFFFE0001, ovf=1.
- mode1, a=7, b=3 -> prod=40 (0x28), ovf=0.
- mode1, a=3, b=7 -> M=10, Q=0xFFFC, prod=0x0009FFD8, ovf=1.
- Handshake, start held high: a=2, b=2 then a=4, b=4 applied at the DONE cycle -> results 4 then 16, exactly 17 cycles apart. A start pulse mid-RUN is ignored and prod is unchanged.
- Reset asserted at RUN cycle 8 -> next cycle IDLE, prod=0, no done pulse. A following start with a=6, b=7 -> prod=42.

Source files
------------

// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared definitions for the sequential multiplier: FSM state
//               encoding, mode selector values and a counter-width helper.
// Revision    : 1.0  initial release
// ============================================================================
package seq_mul_pkg;

    // Controller states: idle, iterating, one-cycle result strobe
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Operation select
    localparam logic MODE_MUL = 1'b0;   // a*b
    localparam logic MODE_DSQ = 1'b1;   // (a+b)*(a-b)

    // Bits needed to count 0..value-1; never less than one bit
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage : seq_mul_pkg
`default_nettype wire

// File: rtl/seq_mul_prep.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_prep
// Description : Combinational operand preparation. Produces the multiplicand
//               m and multiplier q from the raw operands and the mode.
//               In difference-of-squares mode the sum and difference wrap
//               modulo 2^WIDTH (carry and borrow are discarded).
// Ports       : mode   in   operation select (MODE_MUL / MODE_DSQ)
//               a, b   in   WIDTH-bit operands
//               m, q   out  WIDTH-bit multiplicand / multiplier
// Revision    : 1.0  initial release
// ============================================================================
module seq_mul_prep
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        m = a;
        q = b;
        if (mode == MODE_DSQ) begin
            m = a + b;
            q = a - b;
        end
    end

endmodule : seq_mul_prep
`default_nettype wire

// File: rtl/seq_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_unit
// Description : Iterative shift-and-add multiplier with start/busy/done
//               handshake. One multiplier bit is retired per clock, so every
//               operation takes exactly WIDTH RUN cycles followed by a single
//               DONE cycle. The result register only changes on the edge that
//               enters DONE, so partial sums are never visible.
// Ports       : clk    in   system clock
//               re     in   synchronous active-high reset
//               start  in   request, honoured in IDLE or DONE
//               mode   in   0: a*b, 1: (a+b)*(a-b)
//               a, b   in   WIDTH-bit operands, captured on accept
//               busy   out  high while iterating
//               done   out  one-cycle completion pulse
//               prod   out  2*WIDTH-bit result, held until next completion
//               ovf    out  upper half of prod is nonzero
// Revision    : 1.0  initial release
// ============================================================================
module seq_mul_unit
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               re,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod,
    output logic               ovf
);

    localparam int             c_cnt_w = clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [WIDTH-1:0]       r_m;
    logic [WIDTH-1:0]       r_q;
    logic [2*WIDTH-1:0]     r_p;
    logic                   r_busy;
    logic                   r_done;
    logic [2*WIDTH-1:0]     r_prod;
    logic                   r_ovf;

    logic [WIDTH-1:0]       w_m;
    logic [WIDTH-1:0]       w_q;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_p_next;

    seq_mul_prep #(
        .WIDTH (WIDTH)
    ) u_prep (
        .mode (mode),
        .a    (a),
        .b    (b),
        .m    (w_m),
        .q    (w_q)
    );

    // Add the multiplicand into the upper half when the current multiplier
    // bit is set; the extra sum bit holds the carry so that the right shift
    // of {carry, P} keeps the product exact.
    assign w_sum    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_q[0] ? r_m : '0)};
    assign w_p_next = {w_sum, r_p[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (re) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_p     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prod  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_m     <= w_m;
                        r_q     <= w_q;
                        r_p     <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_p <= w_p_next;
                    r_q <= r_q >> 1;
                    if (r_cnt == c_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_prod  <= w_p_next;
                        r_ovf   <= |w_p_next[2*WIDTH-1:WIDTH];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign prod = r_prod;
    assign ovf  = r_ovf;

endmodule : seq_mul_unit
`default_nettype wire

// File: tb/tb_seq_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul_unit
// Description : Self-checking bench for seq_mul_unit. Expected results come
//               from plain arithmetic on the operands; handshake timing is
//               checked against the fixed WIDTH-cycle run length.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mul_unit;

    localparam int W = 16;

    logic           clk;
    logic           re;
    logic           start;
    logic           mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] prod;
    logic           ovf;

    int checks;
    int errors;
    int cyc;

    seq_mul_unit #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .re    (re),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .prod  (prod),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: exact unsigned product of the prepared operands
    function automatic logic [63:0] ref_prod(input logic m, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] mask;
        logic [63:0] mm;
        logic [63:0] qq;
        mask = (64'd1 << W) - 64'd1;
        if (m) begin
            mm = (x + y) & mask;
            qq = (x - y) & mask;
        end else begin
            mm = x & mask;
            qq = y & mask;
        end
        return mm * qq;
    endfunction

    // One complete operation; optionally pokes start in the middle of RUN
    task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
        logic [63:0]    exp;
        logic [2*W-1:0] old;
        int             nbusy;
        int             guard;
        exp = ref_prod(m, 64'(x), 64'(y));
        old = prod;
        @(negedge clk);
        start = 1'b1; mode = m; a = x; b = y;
        @(negedge clk);
        start = 1'b0; mode = ~m; a = W'($urandom); b = W'($urandom);
        nbusy = 0;
        guard = 0;
        while (!done && guard < W + 4) begin
            if (busy) nbusy = nbusy + 1;
            if (nbusy == W / 2) chk("prod_hold", 64'(prod), 64'(old));
            start = (poke && nbusy == W / 2);
            if (start) begin
                a = W'($urandom); b = W'($urandom);
            end
            @(negedge clk);
            guard = guard + 1;
        end
        start = 1'b0;
        chk("done", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("run_len", 64'(nbusy), 64'(W));
        chk("prod", 64'(prod), exp);
        chk("ovf", 64'(ovf), 64'(exp[63:W] != 0));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    task automatic wait_done(output bit ok);
        int guard;
        ok = 1'b0;
        guard = 0;
        while (!done && guard < W + 4) begin
            @(negedge clk);
            guard = guard + 1;
        end
        ok = done;
    endtask

    initial begin
        bit ok;
        int t1;
        int t2;
        int n;
        checks = 0;
        errors = 0;
        re = 1'b1; start = 1'b1; mode = 1'b0; a = 16'd5; b = 16'd5;

        // Reset with start held high
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", 64'(prod), 64'd0);
        chk("rst_ovf",  64'(ovf),  64'd0);
        re = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_norun", 64'(busy), 64'd0);

        // Directed cases
        run_op(1'b0, 16'd3, 16'd5, 1'b0);
        chk("dir_3x5", 64'(prod), 64'h0000_000F);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        chk("dir_max", 64'(prod), 64'hFFFE_0001);
        chk("dir_max_ovf", 64'(ovf), 64'd1);
        run_op(1'b1, 16'd7, 16'd3, 1'b0);
        chk("dir_dsq73", 64'(prod), 64'd40);
        run_op(1'b1, 16'd3, 16'd7, 1'b0);
        chk("dir_dsq37", 64'(prod), 64'h0009_FFD8);
        run_op(1'b0, 16'd0, 16'd0, 1'b0);

        // Random operations, half with a mid-RUN start poke
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), bit'(i % 2));
        end

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; mode = 1'b0; a = 16'd2; b = 16'd2;
        @(negedge clk);
        wait_done(ok);
        chk("b2b_first_done", 64'(ok), 64'd1);
        t1 = cyc;
        chk("b2b_first", 64'(prod), 64'd4);
        a = 16'd4; b = 16'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_rerun", 64'(busy), 64'd1);
        wait_done(ok);
        chk("b2b_second_done", 64'(ok), 64'd1);
        t2 = cyc;
        chk("b2b_second", 64'(prod), 64'd16);
        chk("b2b_spacing", 64'(t2 - t1), 64'(W + 1));
        @(negedge clk);

        // Reset in the middle of RUN
        start = 1'b1; mode = 1'b0; a = 16'd100; b = 16'd200;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 8) begin
            n = n + 1;
            if (n < 8) @(negedge clk);
        end
        chk("abort_reached", 64'(n), 64'd8);
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_prod", 64'(prod), 64'd0);
        chk("abort_ovf",  64'(ovf),  64'd0);
        n = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done || busy) n = n + 1;
        end
        chk("abort_quiet", 64'(n), 64'd0);
        run_op(1'b0, 16'd6, 16'd7, 1'b0);
        chk("post_abort", 64'(prod), 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_mul_unit
`default_nettype wire
